// File: rtl/lut_neuron_cfg.sv
// Runtime-loadable truth-table neuron: streams a 2^IN_BITS-entry table into distributed RAM, then serves lookups.
// Lookup latency 1 cycle, no backpressure; config accepted at one beat per cycle while cfg_ready is high.
module lut_neuron_cfg #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int CFG_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [CFG_W-1:0]    cfg_data,
  output logic                cfg_ready,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic                table_ok,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
);

  localparam int EPB    = CFG_W / OUT_BITS;
  localparam int NENT   = 1 << IN_BITS;
  localparam int NBEATS = NENT / EPB;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                we;
  logic                last;
  logic [OUT_BITS-1:0] mem [NENT];

  assign last = (cnt == CNT_W'(NBEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A start pulse always restarts the load, even mid-LOAD; it outranks any beat in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = LOAD;
      LOAD:    if (cfg_start) state_nxt = LOAD;
               else if (we && last) state_nxt = ARMED;
      ARMED:   if (cfg_start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == LOAD);
    table_ok  = (state == ARMED);
    we        = (state == LOAD) && cfg_valid && !cfg_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      if (cfg_start)
        cnt <= '0;
      else if (we)
        cnt <= cnt + 1'b1;
      cfg_done <= we && last;
      cfg_err  <= cfg_valid && (state != LOAD);
    end
  end

  // Table RAM carries no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int j = 0; j < EPB; j++)
        mem[IN_BITS'(EPB * int'(cnt) + j)] <= cfg_data[OUT_BITS*j +: OUT_BITS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= table_ok && in_valid;
      if (table_ok && in_valid)
        out_data <= mem[in_data];
    end
  end

endmodule

// File: doc/lut_neuron_cfg.md
# lut_neuron_cfg

Runtime-programmable LUT neuron: the writer side of the fixed truth-table neurons in the HGCAL autoencoder layers. It accepts a 2^IN_BITS-entry truth table over a narrow configuration stream and stores it in distributed RAM. Once armed, it answers registered lookups with the same input-word-to-output-word mapping as a generated neuron. It lets encoder layers be re-trained and reloaded without re-synthesis.

## Interface
- IN_BITS, 8, lookup address width (concatenated quantised fan-in)
- OUT_BITS, 2, output word width per table entry
- CFG_W, 8, config beat width; must be a multiple of OUT_BITS; EPB = CFG_W/OUT_BITS entries per beat
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- cfg_start  in  1  one-cycle pulse: begin (re)load of full table
- cfg_valid  in  1  config beat valid
- cfg_data  in  CFG_W  config beat; entry EPB*k+j = cfg_data[OUT_BITS*j +: OUT_BITS]
- cfg_ready  out  1  high only in LOAD
- cfg_done  out  1  one-cycle pulse after last beat is written
- cfg_err  out  1  one-cycle pulse: cfg_valid seen outside LOAD
- table_ok  out  1  table fully loaded, lookups enabled
- in_valid  in  1  lookup request
- in_data  in  IN_BITS  lookup address, unsigned index into table
- out_valid  out  1  lookup result valid
- out_data  out  OUT_BITS  looked-up entry

## Operation
- States: IDLE, LOAD, ARMED. Reset -> IDLE.
- IDLE: cfg_start -> LOAD, beat counter = 0.
- LOAD: beat accepted when cfg_valid & cfg_ready; writes EPB entries at indices EPB*cnt .. EPB*cnt+EPB-1; cnt increments. On accepting beat NBEATS-1 (NBEATS = 2^IN_BITS/EPB, 64 at defaults): -> ARMED, cfg_done pulses the following cycle, cnt wraps to 0.
- ARMED: cfg_start -> LOAD, table_ok drops same edge, cnt = 0.
- cfg_start in LOAD: restart; cnt = 0; the beat presented in the same cycle is discarded (start wins).
- cfg_valid in IDLE or ARMED: beat ignored, table untouched, cfg_err pulses next cycle.
- Entries already written by an aborted load remain in RAM, but table_ok stays 0 until a complete load.
- Lookup: when table_ok & in_valid, out_data <= table[in_data], out_valid <= 1; else out_valid <= 0 and out_data holds its last value.
- in_valid while table_ok = 0 is dropped silently, with no error.
- Table RAM is not reset; contents are undefined until the first load.

## Timing
- Reset values: cfg_ready 0, cfg_done 0, cfg_err 0, table_ok 0, out_valid 0, out_data 0, state IDLE, cnt 0.
- cfg_ready rises the cycle after cfg_start is sampled. It falls the cycle after the last beat.
- cfg_valid may be held high for back-to-back beats at one beat per cycle. With continuous valid, a full load takes 1 + NBEATS cycles from cfg_start to table_ok.
- table_ok and cfg_done both assert on the cycle after the last beat is accepted.
- Lookup latency: 1 cycle. Throughput: 1 lookup per cycle, no backpressure.
- A lookup issued on the same edge that table_ok rises is dropped. The first valid lookup is issued the cycle table_ok is observed high.
- A lookup issued on the same edge as cfg_start in ARMED is still served from the old table. Later lookups are dropped.
- Async reset mid-load aborts the load: IDLE, table_ok 0, out_valid 0 immediately.

## Test plan
- Reset, then in_valid=1 with in_data=8'h30 -> out_valid stays 0; cfg_ready=0, table_ok=0.
- cfg_start, then 64 back-to-back beats of 8'hFF except beat 12 = 8'hE4 -> cfg_done and table_ok high at cycle 65 after start. Lookups 8'h30..8'h33 return 0,1,2,3 one cycle later; 8'h00 returns 3.
- Same load with cfg_valid toggled every other cycle -> only beats with cfg_ready & cfg_valid counted; table_ok after 64 accepted beats; identical lookup results.
- After 20 beats, pulse cfg_start with cfg_valid=1 -> that beat discarded, cnt=0; table_ok rises only after 64 further beats.
- In ARMED, cfg_valid=1 without cfg_start -> cfg_err pulses one cycle; lookup of 8'h31 is unchanged (1).
- Deassert rst_n at beat 40 -> outputs at reset values asynchronously; a fresh full load then returns correct entries.
